// File: rtl/register_1b.sv
// register_1b: enable-gated storage register with synchronous, active-high
// reset. The default instance holds a single bit; WIDTH widens it for
// datapath staging.
//
// Despite its name, rst_n is active-high (rst_n = 1 resets). The name is
// kept so existing instantiations connect unchanged.
module register_1b #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Storage flops: reset beats enable, enable loads D, otherwise hold.
    // Q comes straight from these flops, so no input reaches it combinationally.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
        if (rst_n) begin
            Q <= RESET_VALUE;
        end else if (en) begin
            Q <= D;
        end
    end

endmodule

// File: tb/tb_register_1b.sv
// tb_register_1b: directed self-checking bench for register_1b.
// Two instances share one clock: the default 1-bit register and an
// 8-bit register with RESET_VALUE = 8'hA5. Inputs change 1 time unit
// after a rising edge, and Q is sampled 1 time unit after the edge.
module tb_register_1b;

    logic       clk = 1'b0;

    // Default (1-bit) instance
    logic       n_rst;
    logic       n_en;
    logic [0:0] n_d;
    logic [0:0] n_q;

    // Wide (8-bit) instance
    logic       w_rst;
    logic       w_en;
    logic [7:0] w_d;
    logic [7:0] w_q;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    register_1b u_dut_narrow (
        .clk   (clk),
        .rst_n (n_rst),
        .en    (n_en),
        .D     (n_d),
        .Q     (n_q)
    );

    register_1b #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut_wide (
        .clk   (clk),
        .rst_n (w_rst),
        .en    (w_en),
        .D     (w_d),
        .Q     (w_q)
    );

    // Single comparison point; 4-state compare so X on Q counts as a mismatch.
    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enable-toggle vectors for the 1-bit instance: {en, D, expected Q}.
    // Starting from Q = 1.
    localparam int N_TOG = 4;
    logic [2:0] tog_vec [N_TOG] = '{
        3'b0_0_1,   // hold
        3'b1_0_0,   // load 0
        3'b0_1_0,   // hold despite D = 1
        3'b1_1_1    // load 1
    };

    initial begin
        n_rst = 1'b0; n_en = 1'b0; n_d = 1'b0;
        w_rst = 1'b0; w_en = 1'b0; w_d = 8'h00;
        @(negedge clk);

        // Reset with enable and data active: reset must win.
        n_rst = 1'b1; n_en = 1'b1; n_d = 1'b1;
        w_rst = 1'b1; w_en = 1'b1; w_d = 8'hFF;
        tick();
        check("reset_priority", {7'd0, n_q}, 8'h00);
        check("wide_reset",     w_q,         8'hA5);

        // Load right after reset deassertion (no recovery cycle).
        n_rst = 1'b0; n_en = 1'b1; n_d = 1'b1;
        w_rst = 1'b0; w_en = 1'b1; w_d = 8'h3C;
        tick();
        check("load_1",    {7'd0, n_q}, 8'h01);
        check("wide_load", w_q,         8'h3C);

        // Hold for three edges with the enable low and data changed.
        n_en = 1'b0; n_d = 1'b0;
        w_en = 1'b0; w_d = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold",      {7'd0, n_q}, 8'h01);
            check("wide_hold", w_q,         8'h3C);
        end

        // Reload with 0.
        n_en = 1'b1; n_d = 1'b0;
        tick();
        check("reload_0", {7'd0, n_q}, 8'h00);

        // Load 1 ahead of the mid-operation reset.
        n_en = 1'b1; n_d = 1'b1;
        tick();
        check("load_before_reset", {7'd0, n_q}, 8'h01);

        // Reset asserted between edges has no effect until the next edge.
        n_rst = 1'b1; n_en = 1'b0;
        #2;
        check("reset_is_sync", {7'd0, n_q}, 8'h01);
        tick();
        check("mid_op_reset", {7'd0, n_q}, 8'h00);

        // Deassert and load on the very next edge.
        n_rst = 1'b0; n_en = 1'b1; n_d = 1'b1;
        tick();
        check("load_after_reset", {7'd0, n_q}, 8'h01);

        // Enable toggled every cycle.
        for (int i = 0; i < N_TOG; i++) begin
            n_en = tog_vec[i][2];
            n_d  = tog_vec[i][1];
            tick();
            check($sformatf("en_toggle_%0d", i), {7'd0, n_q}, {7'd0, tog_vec[i][0]});
        end

        // Wide instance: mid-operation reset, then an immediate load.
        w_rst = 1'b1; w_en = 1'b1; w_d = 8'h00;
        tick();
        check("wide_mid_op_reset", w_q, 8'hA5);
        w_rst = 1'b0; w_en = 1'b1; w_d = 8'h5A;
        tick();
        check("wide_load_after_reset", w_q, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_1b.md
# register_1b

Single-clock, enable-gated storage register with synchronous active-high reset; the default instance holds one bit. It is the basic state-holding element for control flags and datapath staging: it captures `D` on a clock edge only when enabled and holds otherwise. The module is named `register_1b`.

## Interface

Parameters:
- `WIDTH`, default 1: data width of `D` and `Q`, in bits; must be at least 1.
- `RESET_VALUE`, default all zeros (`WIDTH` bits): value loaded into `Q` on reset.

Ports:
- `clk`, input, 1 bit: clock. All state changes occur on the rising edge.
- `rst_n`, input, 1 bit: one clock; reset is synchronous and active-high. The name is kept from the codebase, but polarity is active-high: `rst_n = 1` resets.
- `en`, input, 1 bit: load enable, active-high.
- `D`, input, `WIDTH` bits: data in.
- `Q`, output, `WIDTH` bits: registered data out, driven directly from the storage flops.

## Operation

The register evaluates only at the rising edge of `clk`, in this priority order:
- If `rst_n = 1`, `Q` becomes `RESET_VALUE`. Reset overrides `en` and `D`.
- Else if `en = 1`, `Q` becomes `D`.
- Else `Q` holds its previous value.

General rules:
- There is no combinational path from any input to `Q`.
- With no reset ever applied, `Q` is unknown (X in simulation) until the first enabled load or reset.
- Between edges, inputs have no effect.
- The reset value of every output is `Q = RESET_VALUE`; the default is 0.

## Timing

- Load latency is 1 cycle: `D` is sampled at edge N when `en = 1`, and `Q` shows it right after edge N.
- Reset latency is 1 cycle: `rst_n` high at edge N gives `Q = RESET_VALUE` right after edge N. There is no asynchronous effect; asserting `rst_n` between edges does not change `Q` until the next edge.
- Reset asserted while `en = 1` in the same cycle: reset wins.
- Reset deasserted at edge N with `en = 1`: `D` is loaded at edge N+1. No extra recovery cycle is required.
- Reset asserted mid-operation: the stored value is discarded at the next edge.
- `en` toggled every cycle: each edge with `en = 1` loads and each edge with `en = 0` holds. There is no pipelining of the enable.
- Inputs must meet setup and hold time at the rising edge of `clk`.
- Outputs must settle within the same cycle; benches check `Q` 1 time unit after the edge.

## Test plan

- Reset: drive `rst_n = 1`, `en = 1`, `D = 1`, then one edge → `Q = 0`, which shows reset has priority over the enable.
- Load: drive `rst_n = 0`, `en = 1`, `D = 1`, then one edge → `Q = 1`.
- Hold: from `Q = 1`, drive `en = 0`, `D = 0` for 3 edges → `Q` stays 1.
- Reload: from `Q = 1`, drive `en = 1`, `D = 0`, then one edge → `Q = 0`.
- Mid-operation reset:
  - Load 1, then assert `rst_n = 1` with `en = 0` → `Q = 0` after that edge.
  - Deassert, then `en = 1`, `D = 1` → `Q = 1` on the next edge.
- Wide instance: use `WIDTH = 8` and `RESET_VALUE = 8'hA5`.
  - Reset → `Q = 8'hA5`.
  - Load `8'h3C` → `Q = 8'h3C`.
  - Hold with `en = 0` and `D = 8'hFF` → `Q` stays `8'h3C`.
